// File: rtl/serial_ripple_subtractor.sv
// serial_ripple_subtractor: bit-serial a - b - bin, LSB first, with valid/ready on both sides
module serial_ripple_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] sa, sb, sr;
  logic [CW-1:0] cnt;
  logic br, ai, bi, di, bn, last;
  // One full-subtractor cell; after WIDTH-1 right shifts sa[0]/sb[0] hold the original MSBs
  always_comb begin
    ai = sa[0];
    bi = sb[0];
    di = ai ^ bi ^ br;
    bn = (~ai & bi) | (~(ai ^ bi) & br);
    last = cnt == CW'(WIDTH - 1);
  end
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  // Control FSM and datapath registers; everything freezes while en is low
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sa <= '0;
      sb <= '0;
      sr <= '0;
      br <= 1'b0;
      cnt <= '0;
      diff <= '0;
      bout <= 1'b0;
      ovf <= 1'b0;
    end else if (en) begin
      case (state)
        IDLE: if (in_valid) begin
          sa <= a;
          sb <= b;
          br <= bin;
          cnt <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          sa <= sa >> 1;
          sb <= sb >> 1;
          sr <= {di, sr[WIDTH-1:1]};
          br <= bn;
          cnt <= cnt + 1'b1;
          if (last) begin
            diff <= {di, sr[WIDTH-1:1]};
            bout <= bn;
            ovf <= (ai ^ bi) & (ai ^ di);
            state <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// tb_serial_ripple_subtractor: directed and random checks with a result scoreboard
module tb_serial_ripple_subtractor;
  localparam int W = 8;
  logic clk = 0, rst_n = 0, en = 1, in_valid = 0, out_ready = 0, bin = 0;
  logic in_ready, out_valid, bout, ovf;
  logic [W-1:0] a = '0, b = '0, diff;
  logic [W+1:0] q[$];
  int cmp = 0, errs = 0;

  serial_ripple_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [W+1:0] model(input logic [W-1:0] xa, xb, input logic xbin);
    logic [W:0] f;
    logic ov;
    f = {1'b0, xa} - {1'b0, xb} - {{W{1'b0}}, xbin};
    ov = (xa[W-1] ^ xb[W-1]) & (xa[W-1] ^ f[W-1]);
    return {f[W-1:0], f[W], ov};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    cmp++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  always @(negedge clk) if (rst_n && en) begin
    if (in_valid && in_ready) q.push_back(model(a, b, bin));
    if (out_valid && out_ready) begin
      chk("sb_nonempty", q.size() != 0, 1);
      if (q.size() != 0) chk("sb_result", {diff, bout, ovf}, q.pop_front());
    end
  end

  task automatic send(input logic [W-1:0] xa, xb, input logic xbin);
    a = xa; b = xb; bin = xbin; in_valid = 1;
    @(posedge clk); #1 in_valid = 0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1 n++; end
  endtask

  task automatic accept();
    out_ready = 1;
    @(posedge clk); #1 out_ready = 0;
    chk("post_accept_in_ready", in_ready, 1);
    chk("post_accept_out_valid", out_valid, 0);
  endtask

  task automatic op(input logic [W-1:0] xa, xb, input logic xbin,
                    input logic [W-1:0] ed, input logic eb, eo);
    int n;
    send(xa, xb, xbin);
    wait_valid(n);
    chk("latency", n, W);
    chk("diff", diff, ed);
    chk("bout", bout, eb);
    chk("ovf", ovf, eo);
    accept();
  endtask

  initial begin
    int n;
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outs", {diff, bout, ovf}, 0);
    #10 rst_n = 1;
    @(posedge clk); #1;
    op(8'h5A, 8'h3C, 0, 8'h1E, 0, 0);
    op(8'h00, 8'h01, 0, 8'hFF, 1, 0);
    op(8'h10, 8'h0F, 1, 8'h00, 0, 0);
    op(8'h80, 8'h01, 0, 8'h7F, 0, 1);
    op(8'h7F, 8'hFF, 0, 8'h80, 1, 1);
    send(8'h5A, 8'h3C, 0);
    in_valid = 1; a = 8'hFF; b = 8'h00;
    repeat (2) @(posedge clk);
    #1 en = 0;
    repeat (3) @(posedge clk);
    #1 en = 1;
    wait_valid(n);
    chk("stall_latency", 2 + 3 + n, 11);
    chk("stall_diff", diff, 8'h1E);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_result", {diff, bout, ovf}, {8'h1E, 2'b00});
    end
    in_valid = 0;
    accept();
    repeat (W + 4) @(posedge clk);
    #1 chk("no_spurious_op", out_valid, 0);
    send(8'hAA, 8'h55, 1);
    repeat (4) @(posedge clk);
    #2 rst_n = 0;
    q.delete();
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_outs", {diff, bout, ovf}, 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    op(8'h03, 8'h05, 0, 8'hFE, 1, 0);
    for (int i = 0; i < 12000; i++) begin
      @(posedge clk); #1;
      en = $urandom_range(0, 7) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      in_valid = 1'($urandom_range(0, 1));
      a = W'($urandom);
      b = W'($urandom);
      bin = 1'($urandom);
    end
    en = 1; out_ready = 1; in_valid = 0;
    repeat (30) @(posedge clk);
    #1 chk("drain_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule

// File: doc/serial_ripple_subtractor.md
Name: serial_ripple_subtractor

Overview:
- Bit-serial two's-complement subtractor: computes A - B - Bin one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow.
- Sequential counterpart to the combinational ripple-carry adder chain. Trades WIDTH cycles of latency for one arithmetic cell.
- Sits on the datapath behind a valid/ready handshake on both the operand side and the result side.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  global enable; when low, all state freezes
- in_valid  input  1  operands a, b, bin valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow-in
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH
- bout  output  1  borrow-out (unsigned underflow)
- ovf  output  1  signed overflow

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0, any time, including mid-operation):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, diff=0, bout=0, ovf=0.
  - Internal shift registers, borrow flop and bit counter are cleared.
  - Any in-flight operation is discarded and produces no result.
- en=0: no state, register or counter changes. Outputs hold their current values.
  - in_ready and out_valid stay as decoded from the held state.
  - A handshake does not complete while en=0, even if in_valid/in_ready or out_valid/out_ready are both high.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with en & in_valid: capture a, b into shift registers, load the borrow flop with bin, clear the counter, go to SHIFT.
- SHIFT:
  - in_ready=0, out_valid=0. in_valid and operand inputs are ignored.
  - On each edge with en, process bit i = counter:
    - d_i = a_i ^ b_i ^ br
    - br' = (~a_i & b_i) | (~(a_i ^ b_i) & br)
    - d_i shifts into the MSB of the result register, which is shifted right.
    - a/b registers shift right; counter increments.
  - The edge that processes bit WIDTH-1 (counter = WIDTH-1) also does the following, then goes to DONE:
    - Registers bout = br'.
    - Registers ovf = (a_msb ^ b_msb) & (a_msb ^ d_msb), using the original operand MSBs.
    - Drives the completed result onto diff.
- DONE:
  - out_valid=1, in_ready=0. diff, bout and ovf are stable.
  - On an edge with en & out_ready: go to IDLE. out_valid drops. diff/bout/ovf hold their last values until the next completion.
- Latency: out_valid rises exactly WIDTH enabled edges after the accepting edge. Each en=0 cycle adds one cycle.
- Throughput: one operation per WIDTH+2 cycles minimum. There is no overlap; a new operand is accepted only in IDLE.
- diff, bout and ovf update only on the entry edge to DONE. Their values while in SHIFT are don't-care for the consumer but must not glitch out_valid.
- Arithmetic is exact modulo 2^WIDTH:
  - bout=1 iff unsigned a < b + bin.
  - ovf follows the two's-complement rule: operands of differing sign and a result sign differing from a.
- Counter width is clog2(WIDTH). The counter must not wrap before the transition to DONE.
- out_valid is held high until accepted: backpressure on out_ready of any length is tolerated with no data change.

Test Plan:
- Basic: WIDTH=8, a=0x5A, b=0x3C, bin=0 -> after 8 cycles out_valid=1, diff=0x1E, bout=0, ovf=0.
- Underflow/borrow-in:
  - a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1, ovf=0.
  - a=0x10, b=0x0F, bin=1 -> diff=0x00, bout=0, ovf=0.
- Signed overflow: a=0x80, b=0x01 -> diff=0x7F, bout=0, ovf=1. Also a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
- Enable and backpressure:
  - Drop en for 3 cycles mid-SHIFT -> out_valid rises at cycle 11, not 8, with an unchanged correct result.
  - Hold out_ready=0 for 5 cycles in DONE -> outputs stable.
  - in_valid pulses during SHIFT and DONE are ignored.
- Reset mid-operation: assert rst_n=0 asynchronously at bit 4 -> outputs immediately at reset values.
  - The next operation a=0x03, b=0x05 yields diff=0xFE, bout=1 with no residue from the aborted one.
- Random regression: 10k random a/b/bin with random en/out_ready stalls -> diff/bout/ovf match a reference model, and exactly one result per accepted input.
